// File: rtl/kd_pkg.sv
// kd_pkg -- constants shared by the Kyber/Dilithium butterfly datapath.
//   KQ / KQ_W : Kyber modulus and lane width (two 12-bit lanes per 24-bit word)
//   DQ / DQ_W : Dilithium modulus and lane width (one 23-bit lane, bit 23 unused)
//   MODE_K / MODE_D : mode encoding, identical to the multiplier's mode input
package kd_pkg;

  localparam int KQ   = 3329;
  localparam int DQ   = 8380417;
  localparam int KQ_W = 12;
  localparam int DQ_W = 23;

  localparam logic MODE_K = 1'b0;
  localparam logic MODE_D = 1'b1;

endpackage

// File: rtl/mod_addsub_lane.sv
// mod_addsub_lane -- one modular add/sub lane, purely combinational.
//   Computes (a + b) mod Q and (a - b) mod Q with a single conditional
//   correction each; a and b must already be < Q.
//   Optional feature macro: BF_INTT_HALF_EN -- when defined, both results are
//   additionally multiplied by 2^-1 mod Q (inverse-NTT scaling).
// Parameters:
//   W  lane width in bits
//   Q  modulus (Q < 2^W)
// Ports:
//   a     in   W  top operand
//   b     in   W  reduced product b*w
//   sum   out  W  (a + b) mod Q   [halved when BF_INTT_HALF_EN]
//   diff  out  W  (a - b) mod Q   [halved when BF_INTT_HALF_EN]
module mod_addsub_lane #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic [W-1:0] diff
);

  localparam logic [W:0] QX = (W+1)'(Q);

  logic [W:0]   s_raw;
  logic [W:0]   d_raw;
  logic [W-1:0] s_mod;
  logic [W-1:0] d_mod;

  always_comb begin
    s_raw = {1'b0, a} + {1'b0, b};
    d_raw = {1'b0, a} - {1'b0, b};
    s_mod = W'((s_raw >= QX) ? (s_raw - QX) : s_raw);
    // A borrow out of the subtraction shows up as the extra top bit;
    // adding Q modulo 2^(W+1) brings the value back into [0, Q).
    d_mod = W'(d_raw[W] ? (d_raw + QX) : d_raw);
  end

`ifdef BF_INTT_HALF_EN
  // x/2 mod Q: for odd x, x+Q is even and still fits in W+1 bits since x < Q.
  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return W'(t >> 1);
  endfunction

  assign sum  = halve(s_mod);
  assign diff = halve(d_mod);
`else
  assign sum  = s_mod;
  assign diff = d_mod;
`endif

endmodule

// File: rtl/bf_addsub_stage.sv
// bf_addsub_stage -- butterfly add/sub stage behind the shared modular multiplier.
//   Delays {in_valid, mode, a_in} by MUL_LAT cycles so each beat meets its
//   multiplier result bw_in, then registers a+b*w and a-b*w mod q.
//   Kyber: two independent 12-bit lanes (q=3329); Dilithium: one 23-bit lane
//   (q=8380417). Total latency MUL_LAT+1. A beat counter flags the last output
//   beat of every N_BF-beat frame.
//   Optional feature macro: BF_INTT_HALF_EN (results scaled by 2^-1 mod q,
//   no extra latency).
// Parameters:
//   MUL_LAT  multiplier latency in cycles (>= 1)
//   N_BF     butterflies per stage frame
// Ports:
//   clk        in   1   clock
//   rst        in   1   synchronous active-low reset
//   in_valid   in   1   a_in/mode beat valid (same cycle as multiplier launch)
//   mode       in   1   0 = Kyber dual-lane, 1 = Dilithium
//   a_in       in   24  top operand, {hi,lo} for Kyber, {1'b0,a} for Dilithium
//   bw_in      in   24  multiplier result, MUL_LAT cycles after its in_valid
//   out_valid  out  1   outputs valid
//   out_sum    out  24  (a + b*w) mod q, packed like a_in
//   out_diff   out  24  (a - b*w) mod q, packed like a_in
//   out_last   out  1   last beat of a frame
module bf_addsub_stage
  import kd_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int N_BF    = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mode,
  input  logic [23:0] a_in,
  input  logic [23:0] bw_in,
  output logic        out_valid,
  output logic [23:0] out_sum,
  output logic [23:0] out_diff,
  output logic        out_last
);

  localparam int CNT_W = (N_BF > 1) ? $clog2(N_BF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BF - 1);

  // ---------------------------------------------------------------
  // Delay line: free-running, only the valid bits need clearing.
  // ---------------------------------------------------------------
  logic [MUL_LAT-1:0] valid_pipe_reg;
  logic [MUL_LAT-1:0] mode_pipe_reg;
  logic [23:0]        a_pipe_reg [MUL_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_pipe_reg[0] <= 1'b0;
    end else begin
      valid_pipe_reg[0] <= in_valid;
    end
    mode_pipe_reg[0] <= mode;
    a_pipe_reg[0]    <= a_in;
  end

  generate
    for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_delay
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_pipe_reg[gi] <= 1'b0;
        end else begin
          valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
        end
        mode_pipe_reg[gi] <= mode_pipe_reg[gi-1];
        a_pipe_reg[gi]    <= a_pipe_reg[gi-1];
      end
    end
  endgenerate

  logic        valid_d;
  logic        mode_d;
  logic [23:0] a_d;

  assign valid_d = valid_pipe_reg[MUL_LAT-1];
  assign mode_d  = mode_pipe_reg[MUL_LAT-1];
  assign a_d     = a_pipe_reg[MUL_LAT-1];

  // ---------------------------------------------------------------
  // Lanes: both modes are computed every cycle, the delayed mode picks.
  // ---------------------------------------------------------------
  logic [KQ_W-1:0] k_hi_sum, k_hi_diff, k_lo_sum, k_lo_diff;
  logic [DQ_W-1:0] d_sum, d_diff;

  mod_addsub_lane #(.W(KQ_W), .Q(KQ)) u_lane_k_hi (
    .a    (a_d[23:12]),
    .b    (bw_in[23:12]),
    .sum  (k_hi_sum),
    .diff (k_hi_diff)
  );

  mod_addsub_lane #(.W(KQ_W), .Q(KQ)) u_lane_k_lo (
    .a    (a_d[11:0]),
    .b    (bw_in[11:0]),
    .sum  (k_lo_sum),
    .diff (k_lo_diff)
  );

  mod_addsub_lane #(.W(DQ_W), .Q(DQ)) u_lane_d (
    .a    (a_d[22:0]),
    .b    (bw_in[22:0]),
    .sum  (d_sum),
    .diff (d_diff)
  );

  logic [23:0] sum_next;
  logic [23:0] diff_next;

  always_comb begin
    sum_next  = {k_hi_sum, k_lo_sum};
    diff_next = {k_hi_diff, k_lo_diff};
    if (mode_d == MODE_D) begin
      sum_next  = {1'b0, d_sum};
      diff_next = {1'b0, d_diff};
    end
  end

  // ---------------------------------------------------------------
  // Output registers and frame counter.
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sum   <= '0;
      out_diff  <= '0;
      count_reg <= '0;
    end else begin
      out_valid <= valid_d;
      out_last  <= valid_d && (count_reg == CNT_LAST);
      if (valid_d) begin
        out_sum   <= sum_next;
        out_diff  <= diff_next;
        count_reg <= (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bf_addsub_stage.sv
// tb_bf_addsub_stage -- directed self-checking bench for bf_addsub_stage.
//   Beats are queued per cycle, then played; bw_in for each beat is driven
//   MUL_LAT cycles after its in_valid. A monitor records every output beat.
//   Build with +define+BF_INTT_HALF_EN to check the halving variant.
module tb_bf_addsub_stage;

  localparam int MUL_LAT = 4;
  localparam int N_BF    = 128;
  localparam int KQ_T    = 3329;
  localparam int DQ_T    = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic [23:0] a_in = '0;
  logic [23:0] bw_in = '0;
  logic        out_valid;
  logic [23:0] out_sum;
  logic [23:0] out_diff;
  logic        out_last;

  bf_addsub_stage #(.MUL_LAT(MUL_LAT), .N_BF(N_BF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .a_in      (a_in),
    .bw_in     (bw_in),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        v;
    logic        m;
    logic [23:0] a;
    logic [23:0] bw;
  } beat_t;

  typedef struct {
    logic [23:0] s;
    logic [23:0] d;
    logic        l;
    int          c;
  } obs_t;

  beat_t sched[$];
  obs_t  obs[$];
  int    in_cyc[$];

  always @(negedge clk) begin
    if (rst && out_valid) obs.push_back('{out_sum, out_diff, out_last, cyc});
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected-value helpers: value/2 mod q when halving is built in.
  function automatic int hv(input int x, input int q);
`ifdef BF_INTT_HALF_EN
    return (x % 2 == 0) ? x / 2 : (x + q) / 2;
`else
    if (q < 0) return 0;
    return x;
`endif
  endfunction

  function automatic logic [23:0] pk(input int m, input int hi, input int lo);
    if (m != 0) return 24'(lo);
    return {12'(hi), 12'(lo)};
  endfunction

  function automatic logic [23:0] ex(input int m, input int hi, input int lo);
    if (m != 0) return {1'b0, 23'(hv(lo, DQ_T))};
    return {12'(hv(hi, KQ_T)), 12'(hv(lo, KQ_T))};
  endfunction

  task automatic add_beat(input logic m, input logic [23:0] a, input logic [23:0] bw);
    sched.push_back('{1'b1, m, a, bw});
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++) sched.push_back('{1'b0, 1'b0, 24'h0, 24'h0});
  endtask

  task automatic play();
    int n;
    n = sched.size();
    in_cyc.delete();
    obs.delete();
    for (int c = 0; c < n + MUL_LAT + 3; c++) begin
      @(posedge clk); #1;
      if (c < n) begin
        in_valid = sched[c].v;
        mode     = sched[c].m;
        a_in     = sched[c].a;
        if (sched[c].v) in_cyc.push_back(cyc);
      end else begin
        in_valid = 1'b0;
      end
      bw_in = (c >= MUL_LAT && c - MUL_LAT < n) ? sched[c - MUL_LAT].bw : 24'h0;
    end
    sched.delete();
  endtask

  task automatic frame_checks(input string tag);
    int lasts, bad;
    lasts = 0;
    bad   = 0;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i].l) lasts++;
      if (obs[i].l !== ((i + 1) % N_BF == 0)) bad++;
    end
    check({tag, "_beats"}, obs.size(), 2 * N_BF);
    check({tag, "_nlast"}, lasts, 2);
    check({tag, "_lastpos_err"}, bad, 0);
  endtask

  // Streaming table: mode, a_hi, a_lo, b_hi, b_lo, sum_hi, sum_lo, diff_hi, diff_lo
  // (Dilithium rows use the *_lo columns for the full 23-bit value).
  int tbl [10][9] = '{
    '{0,    1,       2,    3,       4,  4,       6, 3327,    3327},
    '{1,    0,    1000,    0,    2000,  0,    3000,    0, 8379417},
    '{0, 3328,    3328,    1,    3328,  0,    3327, 3327,       0},
    '{1,    0, 8380416,    0, 8380416,  0, 8380415,    0,       0},
    '{0,    0,       0,    0,       1,  0,       1,    0,    3328},
    '{1,    0,       5,    0,       0,  0,       5,    0,       5},
    '{0, 2000,    1500, 1329,    1829,  0,       0,  671,    3000},
    '{1,    0, 4190208,    0, 4190209,  0,       0,    0, 8380416},
    '{0,   10,      20,   30,      40, 40,      60, 3309,    3309},
    '{1,    0,     100,    0,       7,  0,     107,    0,      93}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last,  0);
    check("rst_sum",   out_sum,   0);
    check("rst_diff",  out_diff,  0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Test 1: Kyber dual lane, plus latency
    add_beat(1'b0, {12'd100, 12'd3000}, {12'd3300, 12'd500});
    play();
    check("k1_nout", obs.size(), 1);
    if (obs.size() >= 1 && in_cyc.size() >= 1) begin
      check("k1_latency", obs[0].c - in_cyc[0], MUL_LAT + 1);
      check("k1_sum",  obs[0].s, ex(0, 71, 171));
      check("k1_diff", obs[0].d, ex(0, 129, 2500));
      $display("k1: sum=%h diff=%h", obs[0].s, obs[0].d);
    end

    // Test 2: Dilithium edge values; a_in bit 23 set on the second beat
    add_beat(1'b1, 24'd8380416, 24'd1);
    add_gap(2);
    add_beat(1'b1, 24'h800000, 24'd5);
    play();
    check("d2_nout", obs.size(), 2);
    if (obs.size() >= 2) begin
      check("d2a_sum",  obs[0].s, ex(1, 0, 0));
      check("d2a_diff", obs[0].d, ex(1, 0, 8380415));
      check("d2b_sum",  obs[1].s, ex(1, 0, 5));
      check("d2b_diff", obs[1].d, ex(1, 0, 8380412));
      check("d2b_bit23", {31'd0, obs[1].s[23] | obs[1].d[23]}, 0);
      $display("d2: sum=%h diff=%h / sum=%h diff=%h", obs[0].s, obs[0].d, obs[1].s, obs[1].d);
    end

    // Test 3: 10 back-to-back beats alternating mode
    for (int i = 0; i < 10; i++)
      add_beat(tbl[i][0][0], pk(tbl[i][0], tbl[i][1], tbl[i][2]), pk(tbl[i][0], tbl[i][3], tbl[i][4]));
    play();
    check("s3_nout", obs.size(), 10);
    if (obs.size() >= 10) begin
      check("s3_contig", obs[9].c - obs[0].c, 9);
      for (int i = 0; i < 10; i++) begin
        check($sformatf("s3_sum%0d", i),  obs[i].s, ex(tbl[i][0], tbl[i][5], tbl[i][6]));
        check($sformatf("s3_diff%0d", i), obs[i].d, ex(tbl[i][0], tbl[i][7], tbl[i][8]));
        $display("s3 beat %0d mode %0d: sum=%h diff=%h", i, tbl[i][0], obs[i].s, obs[i].d);
      end
    end

    // Test 5: reset with 3 beats in flight
    obs.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      mode     = 1'b0;
      a_in     = {12'd7, 12'd9};
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (MUL_LAT + 4) @(posedge clk);
    @(negedge clk);
    check("r5_nout", obs.size(), 0);
    check("r5_sum",  out_sum,  0);
    $display("r5: outputs after mid-flight reset = %0d", obs.size());

    // Test 4: two back-to-back frames
    for (int i = 0; i < 2 * N_BF; i++) add_beat(1'b0, {12'd1, 12'd2}, {12'd3, 12'd4});
    play();
    frame_checks("f4");
    $display("f4: %0d output beats", obs.size());

    // Test 4b: two frames with 3-cycle gaps
    for (int i = 0; i < 2 * N_BF; i++) begin
      if (i == 60 || i == 127 || i == 200) add_gap(3);
      add_beat(1'b1, 24'd10, 24'd20);
    end
    play();
    frame_checks("f4g");
    $display("f4g: %0d output beats", obs.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
